sync_bus_capture: RTL and testbench

Stability-qualified capture stage that sits directly downstream of the multi-bit two-flop bus synchronizer. It consumes the synchronizer's output word. It publishes a new value only after that word has held constant for a programmable number of consecutive cycles, which filters the transient mixed-bit words a multi-bit crossing can produce. Each accepted change produces a one-cycle update strobe. Each abandoned transition increments a saturating reject counter for debug visibility.

---
 rtl/sync_bus_pkg.sv | 13 +
 rtl/sync_bus_gray2bin.sv | 14 +
 rtl/sync_bus_capture.sv | 91 +++++++++
 tb/tb_sync_bus_capture.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sync_bus_pkg.sv
// sync_bus_pkg: shared FSM state type, qualification limit and Gray decode for sync_bus_capture.
package sync_bus_pkg;
  typedef enum logic {STABLE, SETTLE} state_t;
  localparam int MAX_STABLE_CYCLES = 255;
  localparam int GRAY_MAX_W = 256;
  // Callers zero-extend narrower words; leading zeros do not change the lower decoded bits.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/sync_bus_gray2bin.sv
// sync_bus_gray2bin: combinational WIDTH-bit Gray-to-binary converter.
module sync_bus_gray2bin
  import sync_bus_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);
  if (WIDTH > GRAY_MAX_W) begin : g_bad_width
    $error("sync_bus_gray2bin: WIDTH exceeds GRAY_MAX_W");
  end
  assign bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
endmodule

// File: rtl/sync_bus_capture.sv
// sync_bus_capture: publishes din only after it holds for STABLE_CYCLES samples; counts abandoned candidates.
// Define SYNC_BUS_CAPTURE_GRAY_EN to treat din as Gray code (decoded to binary before comparison).
module sync_bus_capture
  import sync_bus_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int STABLE_CYCLES = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 en,
  input  logic                 clr_cnt,
  output logic [WIDTH-1:0]     dout,
  output logic                 update,
  output logic                 settling,
  output logic [CNT_WIDTH-1:0] reject_cnt
);
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
    $error("sync_bus_capture: STABLE_CYCLES out of range");
  end
  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] w;
`ifdef SYNC_BUS_CAPTURE_GRAY_EN
  sync_bus_gray2bin #(.WIDTH(WIDTH)) u_gray2bin (.gray(din), .bin(w));
`else
  assign w = din;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d, dout_q, dout_d;
  logic [7:0] cnt_q, cnt_d;
  logic update_q, update_d, rej_inc;
  logic [CNT_WIDTH-1:0] rej_q, rej_d;
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    update_d = 1'b0;
    rej_inc  = 1'b0;
    if (!en) begin
      state_d = STABLE;
      cnt_d   = '0;
    end else if (state_q == STABLE) begin
      if (w != dout_q && STABLE_CYCLES == 1) begin
        dout_d   = w;
        update_d = 1'b1;
      end else if (w != dout_q) begin
        cand_d  = w;
        cnt_d   = 8'd1;
        state_d = SETTLE;
      end
    end else if (w == dout_q) begin
      state_d = STABLE;
      rej_inc = 1'b1;
    end else if (w != cand_q) begin
      cand_d  = w;
      cnt_d   = 8'd1;
      rej_inc = 1'b1;
    end else if (cnt_q == LAST) begin
      dout_d   = cand_q;
      update_d = 1'b1;
      state_d  = STABLE;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
    rej_d = clr_cnt ? '0 : (rej_inc && !(&rej_q)) ? rej_q + CNT_WIDTH'(1) : rej_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STABLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      update_q <= 1'b0;
      rej_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      update_q <= update_d;
      rej_q    <= rej_d;
    end
  end
  assign dout       = dout_q;
  assign update     = update_q;
  assign settling   = state_q == SETTLE;
  assign reject_cnt = rej_q;
endmodule

// File: tb/tb_sync_bus_capture.sv
// tb_sync_bus_capture: directed and randomized checks of sync_bus_capture against a run-length reference model.
module tb_sync_bus_capture;
  localparam int N = 3;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, clr_cnt = 1'b0;
  logic [31:0] din = '0, dout_a, dout_b;
  logic upd_a, upd_b, set_a, set_b;
  logic [15:0] rej_a;
  logic [1:0] rej_b;
  int checks = 0, failures = 0;
  logic [31:0] m_dout, run_v;
  logic m_upd, m_set;
  int run_n, m_rej_a, m_rej_b;

  sync_bus_capture #(.WIDTH(32), .STABLE_CYCLES(N), .CNT_WIDTH(16)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_cnt(clr_cnt),
    .dout(dout_a), .update(upd_a), .settling(set_a), .reject_cnt(rej_a));
  sync_bus_capture #(.WIDTH(32), .STABLE_CYCLES(N), .CNT_WIDTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr_cnt(clr_cnt),
    .dout(dout_b), .update(upd_b), .settling(set_b), .reject_cnt(rej_b));

  always #5 clk = ~clk;

  function automatic logic [31:0] dec(input logic [31:0] x);
`ifdef SYNC_BUS_CAPTURE_GRAY_EN
    logic [31:0] b = '0;
    for (int i = 0; i < 32; i++) b ^= x >> i;
    return b;
`else
    return x;
`endif
  endfunction

  task automatic model_reset();
    m_dout = '0; run_v = '0; run_n = 0; m_upd = 0; m_set = 0; m_rej_a = 0; m_rej_b = 0;
  endtask

  // Accept a value once it has been seen N samples in a row and differs from dout;
  // a run of a non-published value that ends early is a rejection.
  task automatic model_step(input logic [31:0] d, input logic e, input logic c);
    logic [31:0] w;
    bit inc = 0;
    m_upd = 0;
    if (!e) run_n = 0;
    else begin
      w = dec(d);
      if (run_n > 0 && w == run_v) run_n++;
      else begin
        inc = run_n > 0 && run_v != m_dout;
        run_v = w;
        run_n = 1;
      end
      if (run_v != m_dout && run_n == N) begin
        m_dout = run_v;
        m_upd = 1;
      end
    end
    m_set = e && run_n > 0 && run_v != m_dout;
    m_rej_a = c ? 0 : (inc && m_rej_a < 65535) ? m_rej_a + 1 : m_rej_a;
    m_rej_b = c ? 0 : (inc && m_rej_b < 3) ? m_rej_b + 1 : m_rej_b;
  endtask

  task automatic drive(input logic [31:0] d, input logic e = 1'b1, input logic c = 1'b0);
    @(negedge clk);
    din = d; en = e; clr_cnt = c;
    @(posedge clk);
    model_step(d, e, c);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++; if ({dout_a, upd_a, set_a, rej_a} !== '0) begin failures++; $display("FAIL reset_init got dout=%h upd=%b set=%b rej=%0d exp zeros", dout_a, upd_a, set_a, rej_a); end
    @(negedge clk); rst_n = 1'b1;
    drive(32'hFF); drive(32'h0); drive(32'h55); drive(32'h55);
    checks++; if (set_a !== 1'b1 || rej_a !== 16'd1) begin failures++; $display("FAIL reset_pre got set=%b rej=%0d exp set=1 rej=1", set_a, rej_a); end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if ({dout_a, upd_a, set_a, rej_a, rej_b} !== '0) begin failures++; $display("FAIL reset_async got dout=%h upd=%b set=%b rej=%0d exp zeros", dout_a, upd_a, set_a, rej_a); end
    @(negedge clk); din = '0; rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(32'h0);
      checks++; if (upd_a !== 1'b0 || dout_a !== '0) begin failures++; $display("FAIL reset_release got upd=%b dout=%h exp upd=0 dout=0", upd_a, dout_a); end
    end
  endtask

  task automatic test_glitch();
    drive(32'hFF);
    checks++; if (set_a !== 1'b1) begin failures++; $display("FAIL glitch_settle got %b exp 1", set_a); end
    drive(32'h0);
    checks++; if ({dout_a, upd_a, set_a} !== '0 || rej_a !== 16'd1 || rej_b !== 2'd1) begin failures++; $display("FAIL glitch got dout=%h upd=%b set=%b rej=%0d/%0d exp 0 0 0 1/1", dout_a, upd_a, set_a, rej_a, rej_b); end
    drive(32'h0); drive(32'h0);
    checks++; if (upd_a !== 1'b0 || dout_a !== '0) begin failures++; $display("FAIL glitch_after got upd=%b dout=%h exp 0 0", upd_a, dout_a); end
  endtask

  task automatic test_held();
    for (int k = 1; k <= 4; k++) begin
      drive(32'h1234);
      checks++;
      if (set_a !== (k < 3) || upd_a !== (k == 3) || dout_a !== (k >= 3 ? dec(32'h1234) : 32'h0)) begin
        failures++; $display("FAIL held k=%0d got set=%b upd=%b dout=%h exp set=%b upd=%b dout=%h", k, set_a, upd_a, dout_a, k < 3, k == 3, k >= 3 ? dec(32'h1234) : 32'h0);
      end
    end
  endtask

  task automatic test_replace();
    drive(32'hA); drive(32'hA); drive(32'hB);
    checks++; if (rej_a !== 16'd2 || set_a !== 1'b1) begin failures++; $display("FAIL replace_rej got rej=%0d set=%b exp 2 1", rej_a, set_a); end
    drive(32'hB);
    checks++; if (upd_a !== 1'b0 || dout_a !== dec(32'h1234)) begin failures++; $display("FAIL replace_early got upd=%b dout=%h exp 0 %h", upd_a, dout_a, dec(32'h1234)); end
    drive(32'hB);
    checks++; if (upd_a !== 1'b1 || dout_a !== dec(32'hB)) begin failures++; $display("FAIL replace_accept got upd=%b dout=%h exp 1 %h", upd_a, dout_a, dec(32'hB)); end
  endtask

  task automatic test_counter();
    drive(32'hB, 1'b1, 1'b1);
    checks++; if (rej_a !== '0 || rej_b !== '0) begin failures++; $display("FAIL clr got %0d/%0d exp 0/0", rej_a, rej_b); end
    for (int k = 0; k < 5; k++) begin drive(32'h77); drive(32'hB); end
    checks++; if (rej_b !== 2'd3 || rej_a !== 16'd5) begin failures++; $display("FAIL saturate got %0d/%0d exp 5/3", rej_a, rej_b); end
    drive(32'h77); drive(32'hB, 1'b1, 1'b1);
    checks++; if (rej_b !== '0 || rej_a !== '0) begin failures++; $display("FAIL clr_wins got %0d/%0d exp 0/0", rej_a, rej_b); end
  endtask

  task automatic test_enable();
    for (int k = 0; k < 5; k++) drive(32'h99, 1'b0);
    checks++; if (dout_a !== dec(32'hB) || upd_a !== 1'b0 || set_a !== 1'b0) begin failures++; $display("FAIL en_hold got dout=%h upd=%b set=%b exp %h 0 0", dout_a, upd_a, set_a, dec(32'hB)); end
    drive(32'h99); drive(32'h99); drive(32'h99, 1'b0);
    checks++; if (set_a !== 1'b0 || rej_a !== '0 || dout_a !== dec(32'hB)) begin failures++; $display("FAIL en_abort got set=%b rej=%0d dout=%h exp 0 0 %h", set_a, rej_a, dout_a, dec(32'hB)); end
    drive(32'h99); drive(32'h99);
    checks++; if (upd_a !== 1'b0) begin failures++; $display("FAIL en_restart got upd=%b exp 0", upd_a); end
    drive(32'h99);
    checks++; if (upd_a !== 1'b1 || dout_a !== dec(32'h99)) begin failures++; $display("FAIL en_accept got upd=%b dout=%h exp 1 %h", upd_a, dout_a, dec(32'h99)); end
  endtask

`ifdef SYNC_BUS_CAPTURE_GRAY_EN
  task automatic test_gray();
    drive(32'h6); drive(32'h6); drive(32'h6);
    checks++; if (dout_a !== 32'h4 || upd_a !== 1'b1) begin failures++; $display("FAIL gray got dout=%h upd=%b exp 00000004 1", dout_a, upd_a); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] d = '0;
    int hold = 0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        d = ($urandom_range(0, 4) == 4) ? $urandom : 32'($urandom_range(0, 3));
        hold = $urandom_range(1, 5);
      end
      hold--;
      drive(d, $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      checks++;
      if (dout_a !== m_dout || dout_b !== m_dout || upd_a !== m_upd || upd_b !== m_upd || set_a !== m_set || set_b !== m_set) begin
        failures++; $display("FAIL rand_out k=%0d got dout=%h upd=%b set=%b exp dout=%h upd=%b set=%b", k, dout_a, upd_a, set_a, m_dout, m_upd, m_set);
      end
      checks++;
      if (rej_a !== 16'(m_rej_a) || rej_b !== 2'(m_rej_b)) begin
        failures++; $display("FAIL rand_rej k=%0d got %0d/%0d exp %0d/%0d", k, rej_a, rej_b, m_rej_a, m_rej_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_held();
    test_replace();
    test_counter();
    test_enable();
`ifdef SYNC_BUS_CAPTURE_GRAY_EN
    test_gray();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
